// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the pipelined MIPS datapath.
//
// Owns the PC, issues instruction-memory reads and produces the IF/ID latch.
// The latch is a flat 96-bit vector packed as IF_ID_t:
//   if_id[95:64] = imemload, if_id[63:32] = pc, if_id[31:0] = pc4
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   ihit, imemload  instruction memory response
//   imemREN         instruction read request
//   imemaddr        read address (always the current PC)
//   stall           hold the IF/ID latch (decode cannot accept)
//   flush           squash the IF/ID latch
//   redirect        load redirect_pc (word aligned) into the PC
//   halt            stop fetching until reset
//   if_id           IF/ID latch contents
//   if_id_valid     latch holds a real instruction
//
// Optional feature: define FETCH_SKID_EN to add a one-entry skid buffer and
// the HOLD state, so a word arriving during a stall is kept rather than
// refetched. Without it, imemREN drops during a stall and the word is
// refetched once the stall clears.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [95:0] if_id,
  output logic        if_id_valid
);

`ifdef FETCH_SKID_EN
  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;
`else
  typedef enum logic [1:0] {FETCH, HALTED} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc4;
`ifdef FETCH_SKID_EN
  logic [95:0] skid;
`endif

  // The low two bits of a redirect target are discarded.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc4      = pc + 32'd4;
  assign imemaddr = pc;

`ifdef FETCH_SKID_EN
  assign imemREN = (state == FETCH);
`else
  assign imemREN = (state == FETCH) && !stall;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      if_id       <= '0;
      if_id_valid <= 1'b0;
`ifdef FETCH_SKID_EN
      skid        <= '0;
`endif
    end else if (halt) begin
      state       <= HALTED;
      if_id       <= '0;
      if_id_valid <= 1'b0;
`ifdef FETCH_SKID_EN
      skid        <= '0;
`endif
    end else if (state != HALTED) begin
      if (redirect) begin
        // Same-cycle ihit is wrong-path and dropped; the latch is only
        // cleared by an accompanying flush, otherwise it obeys stall.
        pc    <= {redirect_pc[31:2], 2'b00};
        state <= FETCH;
`ifdef FETCH_SKID_EN
        skid  <= '0;
`endif
        if (flush) begin
          if_id       <= '0;
          if_id_valid <= 1'b0;
        end else if (!stall) begin
          if_id_valid <= 1'b0;
        end
      end else if (flush) begin
        // The arriving word is dropped and the PC left in place so the
        // next fetch re-reads it.
        if_id       <= '0;
        if_id_valid <= 1'b0;
        state       <= FETCH;
`ifdef FETCH_SKID_EN
        skid        <= '0;
`endif
      end else if (stall) begin
`ifdef FETCH_SKID_EN
        if (state == FETCH && ihit) begin
          skid  <= {imemload, pc, pc4};
          pc    <= pc4;
          state <= HOLD;
        end
`endif
      end else begin
`ifdef FETCH_SKID_EN
        if (state == HOLD) begin
          if_id       <= skid;
          if_id_valid <= 1'b1;
          skid        <= '0;
          state       <= FETCH;
        end else
`endif
        if (ihit) begin
          if_id       <= {imemload, pc, pc4};
          if_id_valid <= 1'b1;
          pc          <= pc4;
        end else begin
          if_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule
